mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter WORD_LEN, default 32, data/address width.
REQ-002 Parameter MEM_DEPTH, default 256, data memory depth in words.
REQ-003 Parameter MEM_LATENCY, default 2, cycles per memory access, legal range 1..15.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 MEM_R_EN  in  1  load request from EXE/MEM register.
REQ-007 MEM_W_EN  in  1  store request from EXE/MEM register.
REQ-008 WB_EN_in  in  1  writeback enable of the instruction in MEM.
REQ-009 dest_in  in  5  destination register number.
REQ-010 ALU_res_in  in  WORD_LEN  ALU result; byte address for loads/stores.
REQ-011 ST_value_in  in  WORD_LEN  store data, already forwarded by EXE.
REQ-012 ALU_res_MEM  out  WORD_LEN  combinational copy of ALU_res_in for EXE forwarding.
REQ-013 mem_stall  out  1  freeze request to PC, IF/ID, ID/EXE, EXE/MEM registers.
REQ-014 WB_EN_out, MEM_R_EN_out  out  1 each  registered MEM/WB controls.
REQ-015 dest_out  out  5; ALU_res_out, mem_data_out  out  WORD_LEN; registered MEM/WB values.

Function
REQ-016 Word index SHALL be ALU_res_in[log2(MEM_DEPTH)+1:2]; bits [1:0] ignored; upper bits ignored (wrap-around).
REQ-017 FSM states SHALL be IDLE and ACCESS, with 4-bit down-counter cnt.
REQ-018 Request = MEM_R_EN | MEM_W_EN; both asserted SHALL be treated as a store only, mem_data_out=0.
REQ-019 IDLE, no request: mem_stall=0, MEM/WB register captures inputs, mem_data_out<=0.
REQ-020 IDLE, request, MEM_LATENCY=1: access completes same cycle, mem_stall=0, state stays IDLE.
REQ-021 IDLE, request, MEM_LATENCY>=2: mem_stall=1 combinationally, latch index/ST_value/controls, cnt<=MEM_LATENCY-1, go ACCESS.
REQ-022 ACCESS, cnt>1: mem_stall=1, cnt<=cnt-1.
REQ-023 ACCESS, cnt==1: mem_stall=0, access completes using latched values, go IDLE.
REQ-024 On completion, store SHALL write mem[index]<=ST_value at that edge; load SHALL set mem_data_out<=mem[index].
REQ-025 Each access SHALL occupy exactly MEM_LATENCY cycles with mem_stall high for MEM_LATENCY-1 of them.
REQ-026 While mem_stall=1 the MEM/WB register SHALL load a bubble: WB_EN_out=0, MEM_R_EN_out=0, dest_out, ALU_res_out, mem_data_out unchanged.
REQ-027 Upstream SHALL hold inputs stable while mem_stall=1; block SHALL use only latched values in ACCESS regardless.
REQ-028 Back-to-back requests: request present in IDLE on the cycle after completion SHALL start a new access; load following store to same word SHALL return the stored value.
REQ-029 ALU_res_MEM SHALL equal ALU_res_in in every cycle, independent of state and stall.

Reset
REQ-030 rst=1 at clock edge SHALL force IDLE, cnt=0, all MEM/WB outputs 0; mem_stall=0 in the cycle following.
REQ-031 Reset during ACCESS SHALL abort the access; pending store SHALL NOT write.
REQ-032 Memory contents SHALL NOT be cleared by reset; initial contents 0 in simulation.

Verification
REQ-033 MEM_LATENCY=2, store 0xDEADBEEF to addr 0x10 -> mem_stall high 1 cycle, mem[4]=0xDEADBEEF, WB_EN_out=0 during stall.
REQ-034 Load addr 0x12 after that store -> after 2 cycles mem_data_out=0xDEADBEEF, MEM_R_EN_out=1, dest_out=dest_in.
REQ-035 MEM_LATENCY=4, load -> mem_stall high exactly 3 consecutive cycles, result on 4th edge.
REQ-036 MEM_R_EN=MEM_W_EN=1, ST_value 0x55 to addr 0x20 -> mem[8]=0x55, mem_data_out=0.
REQ-037 rst asserted on 2nd cycle of a 4-cycle store -> word unchanged, outputs 0, FSM IDLE.
REQ-038 ALU op (no request), ALU_res_in=7, WB_EN_in=1 -> no stall, next edge ALU_res_out=7, WB_EN_out=1; ALU_res_MEM=7 same cycle.

Source files
------------

// File: rtl/mem_stage.sv
// MEM pipeline stage: data memory with a fixed multi-cycle access latency, a pipeline
// stall request while an access is in flight, and the MEM/WB output register.
module mem_stage #(
  parameter int WORD_LEN    = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int MEM_LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                MEM_R_EN,
  input  logic                MEM_W_EN,
  input  logic                WB_EN_in,
  input  logic [4:0]          dest_in,
  input  logic [WORD_LEN-1:0] ALU_res_in,
  input  logic [WORD_LEN-1:0] ST_value_in,
  output logic [WORD_LEN-1:0] ALU_res_MEM,
  output logic                mem_stall,
  output logic                WB_EN_out,
  output logic                MEM_R_EN_out,
  output logic [4:0]          dest_out,
  output logic [WORD_LEN-1:0] ALU_res_out,
  output logic [WORD_LEN-1:0] mem_data_out
);

  localparam int AW = $clog2(MEM_DEPTH);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t              state, state_n;
  logic [3:0]          cnt;
  logic [WORD_LEN-1:0] mem [MEM_DEPTH];

  logic                req, start, complete;
  logic [AW-1:0]       in_idx;

  // Request captured at access start; ACCESS works only from these copies.
  logic [AW-1:0]       idx_q;
  logic [WORD_LEN-1:0] st_q, alu_q;
  logic                store_q, load_q, wb_q;
  logic [4:0]          dest_q;

  // Values presented to the memory and the MEM/WB register on completion.
  logic [AW-1:0]       c_idx;
  logic [WORD_LEN-1:0] c_data, c_alu;
  logic                c_store, c_load, c_wb;
  logic [4:0]          c_dest;

  assign ALU_res_MEM = ALU_res_in;
  assign req         = MEM_R_EN | MEM_W_EN;
  assign in_idx      = ALU_res_in[AW+1:2];

  always_comb begin
    state_n   = state;
    mem_stall = 1'b0;
    start     = 1'b0;
    complete  = 1'b0;
    c_store   = 1'b0;
    c_load    = 1'b0;
    c_idx     = in_idx;
    c_data    = ST_value_in;
    c_wb      = WB_EN_in;
    c_dest    = dest_in;
    c_alu     = ALU_res_in;
    case (state)
      IDLE: begin
        if (!req) begin
          complete = 1'b1;
        end else if (MEM_LATENCY == 1) begin
          complete = 1'b1;
          c_store  = MEM_W_EN;
          c_load   = MEM_R_EN & ~MEM_W_EN;
        end else begin
          mem_stall = 1'b1;
          start     = 1'b1;
          state_n   = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt > 4'd1) begin
          mem_stall = 1'b1;
        end else begin
          complete = 1'b1;
          state_n  = IDLE;
          c_store  = store_q;
          c_load   = load_q;
          c_idx    = idx_q;
          c_data   = st_q;
          c_wb     = wb_q;
          c_dest   = dest_q;
          c_alu    = alu_q;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // A reset on the completing edge suppresses the write, so aborted stores never land.
  always_ff @(posedge clk) begin
    if (!rst && complete && c_store) mem[c_idx] <= c_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      idx_q        <= '0;
      st_q         <= '0;
      alu_q        <= '0;
      store_q      <= 1'b0;
      load_q       <= 1'b0;
      wb_q         <= 1'b0;
      dest_q       <= '0;
      WB_EN_out    <= 1'b0;
      MEM_R_EN_out <= 1'b0;
      dest_out     <= '0;
      ALU_res_out  <= '0;
      mem_data_out <= '0;
    end else begin
      state <= state_n;
      if (start) begin
        cnt     <= 4'(MEM_LATENCY - 1);
        idx_q   <= in_idx;
        st_q    <= ST_value_in;
        alu_q   <= ALU_res_in;
        store_q <= MEM_W_EN;
        load_q  <= MEM_R_EN & ~MEM_W_EN;
        wb_q    <= WB_EN_in;
        dest_q  <= dest_in;
      end else if (state == ACCESS) begin
        cnt <= mem_stall ? cnt - 4'd1 : '0;
      end
      if (mem_stall) begin
        WB_EN_out    <= 1'b0;
        MEM_R_EN_out <= 1'b0;
      end else if (complete) begin
        WB_EN_out    <= c_wb;
        MEM_R_EN_out <= c_load;
        dest_out     <= c_dest;
        ALU_res_out  <= c_alu;
        mem_data_out <= c_load ? mem[c_idx] : '0;
      end
    end
  end

endmodule
